// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor with a valid/ready stream interface.
// The carry chain is cut into STAGES registered chunks of WIDTH/STAGES bits each.
module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = WIDTH / STAGES;

    logic [WIDTH-1:0]              bp;
    logic                          adv;
    logic [STAGES-1:0][WIDTH-1:0]  s_r, b_r, nxt_s, nxt_b;
    logic [STAGES-1:0]             c_r, v_r, nxt_c, nxt_v;
    logic                          ov_r, nxt_ov;
    logic                          unused_last_b;

    assign bp        = sub ? ~b : b;
    assign out_valid = v_r[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // s_r[k] holds the result chunks 0..k plus the still-unconsumed upper chunks of a,
    // so the last stage still sees the original a/b' MSBs for the overflow test.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] src_s, src_b, ns;
        logic             src_c, src_v;
        logic [CW:0]      ch;
        logic             unused_src_b;

        if (k == 0) begin : g_first
            assign src_s = a;
            assign src_b = bp;
            assign src_c = sub;
            assign src_v = in_valid;
        end else begin : g_next
            assign src_s = s_r[k-1];
            assign src_b = b_r[k-1];
            assign src_c = c_r[k-1];
            assign src_v = v_r[k-1];
        end

        assign ch = {1'b0, src_s[k*CW +: CW]} + {1'b0, src_b[k*CW +: CW]} + {{CW{1'b0}}, src_c};

        always_comb begin
            ns              = src_s;
            ns[k*CW +: CW]  = ch[CW-1:0];
        end

        assign nxt_s[k]     = ns;
        assign nxt_b[k]     = src_b;
        assign nxt_c[k]     = ch[CW];
        assign nxt_v[k]     = src_v;
        assign unused_src_b = ^src_b;

        if (k == STAGES - 1) begin : g_last
            assign nxt_ov = (src_s[WIDTH-1] == src_b[WIDTH-1]) && (ch[CW-1] != src_s[WIDTH-1]);
        end
    end

    assign unused_last_b = ^b_r[STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_r  <= '0;
            b_r  <= '0;
            c_r  <= '0;
            v_r  <= '0;
            ov_r <= 1'b0;
        end else if (adv) begin
            s_r  <= nxt_s;
            b_r  <= nxt_b;
            c_r  <= nxt_c;
            v_r  <= nxt_v;
            ov_r <= nxt_ov;
        end
    end

    assign sum       = s_r[STAGES-1];
    assign carry_out = c_r[STAGES-1];
    assign overflow  = ov_r;
    assign zero      = (sum == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: five adder configurations share one operand stream; the 64/2
// instance sees random backpressure, the others always consume.
module tb_pipelined_adder;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        int          t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        iv;
    logic [63:0] a_i, b_i;
    logic        sub_i;
    logic        rdy0;
    logic        bp_phase;
    logic        chk_reset;
    logic        exp_known;
    logic [63:0] es;
    logic        ec, eo;
    int          cyc;
    int          n_cmp;
    int          n_err;
    int          qsize [5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        rdy0 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy0 = bp_phase ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_cfg
        localparam int W = (g == 4) ? 32 : 64;
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : (g == 3) ? 8 : 4;

        logic         ir, ov, orr, c, o, z;
        logic [W-1:0] s;
        exp_t         q [$];

        assign orr = (g == 0) ? rdy0 : 1'b1;

        pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
            .clk       (clk),
            .reset     (rst_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (a_i[W-1:0]),
            .b         (b_i[W-1:0]),
            .sub       (sub_i),
            .out_valid (ov),
            .out_ready (orr),
            .sum       (s),
            .carry_out (c),
            .overflow  (o),
            .zero      (z)
        );

        function automatic exp_t mdl(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic sb, input int t);
            logic [W-1:0] yp;
            logic [W:0]   f;
            exp_t         r;
            yp  = sb ? ~y : y;
            f   = {1'b0, x} + {1'b0, yp} + {{W{1'b0}}, sb};
            r.s = 64'(f[W-1:0]);
            r.c = f[W];
            r.o = (x[W-1] == yp[W-1]) && (f[W-1] != x[W-1]);
            r.t = t;
            return r;
        endfunction

        initial begin
            exp_t         e;
            logic         prev_stall;
            logic [W-1:0] snap_s;
            logic         snap_c, snap_o;
            string        tag;
            prev_stall = 1'b0;
            snap_s = '0;
            snap_c = 1'b0;
            snap_o = 1'b0;
            tag = $sformatf("W%0d_S%0d", W, S);
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    q.delete();
                end else begin
                    if (chk_reset) begin
                        chk({tag, " rst out_valid"}, 64'(ov), 64'(0));
                        chk({tag, " rst sum"},       64'(s),  64'(0));
                        chk({tag, " rst carry"},     64'(c),  64'(0));
                        chk({tag, " rst overflow"},  64'(o),  64'(0));
                        chk({tag, " rst zero"},      64'(z),  64'(1));
                        chk({tag, " rst in_ready"},  64'(ir), 64'(1));
                    end
                    if (prev_stall) begin
                        chk({tag, " hold valid"}, 64'(ov), 64'(1));
                        chk({tag, " hold sum"},   64'(s),  64'(snap_s));
                        chk({tag, " hold flags"}, 64'({c, o}), 64'({snap_c, snap_o}));
                    end
                    if (ov && orr) begin
                        if (q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL %s unexpected output: got sum %h expected none", tag, s);
                        end else begin
                            e = q.pop_front();
                            chk({tag, " sum"},      64'(s), e.s);
                            chk({tag, " carry"},    64'(c), 64'(e.c));
                            chk({tag, " overflow"}, 64'(o), 64'(e.o));
                            chk({tag, " zero"},     64'(z), 64'(e.s == 64'd0));
                            if (g != 0 || !bp_phase)
                                chk({tag, " latency"}, 64'(cyc - e.t), 64'(S));
                            else
                                chk({tag, " latency min"}, 64'(cyc - e.t >= S), 64'(1));
                        end
                    end
                    if (iv && ir) begin
                        if (exp_known && W == 64) begin
                            e.s = es;
                            e.c = ec;
                            e.o = eo;
                            e.t = cyc;
                        end else begin
                            e = mdl(a_i[W-1:0], b_i[W-1:0], sub_i, cyc);
                        end
                        q.push_back(e);
                    end
                end
                prev_stall = rst_n && ov && !orr;
                snap_s = s;
                snap_c = c;
                snap_o = o;
                qsize[g] = q.size();
            end
        end
    end

    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic sb,
                        input logic known, input logic [63:0] xs, input logic xc, input logic xo);
        bit ok;
        a_i = x;
        b_i = y;
        sub_i = sb;
        exp_known = known;
        es = xs;
        ec = xc;
        eo = xo;
        iv = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (g_cfg[0].ir) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept timeout: got in_ready 0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        iv = 1'b0;
    endtask

    task automatic drain();
        int pending;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pending = 0;
            for (int k = 0; k < 5; k++) pending += qsize[k];
            if (pending == 0) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset_check();
        chk_reset = 1'b1;
        @(negedge clk);
        #1;
        chk_reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        iv = 1'b0;
        a_i = '0;
        b_i = '0;
        sub_i = 1'b0;
        bp_phase = 1'b0;
        chk_reset = 1'b0;
        exp_known = 1'b0;
        es = '0;
        ec = 1'b0;
        eo = 1'b0;
        for (int k = 0; k < 5; k++) qsize[k] = 0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulse_reset_check();

        send(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h0,                   1'b1, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        send(64'h5,                   64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        send(64'h7,                   64'h5, 1'b1, 1'b1, 64'h2,                   1'b1, 1'b0);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1,
             64'h2222_2222_2222_2211, 1'b0, 1'b0);
        send(64'h0,                   64'h0, 1'b1, 1'b1, 64'h0,                   1'b1, 1'b0);
        drain();

        bp_phase = 1'b1;
        for (int i = 0; i < 10; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'b0, 64'h0, 1'b0, 1'b0);
        drain();
        bp_phase = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset lands while several results are still inside the deeper pipelines.
        for (int i = 0; i < 3; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'b0, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        iv = 1'b1;
        a_i = 64'h1;
        b_i = 64'h1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        iv = 1'b0;
        pulse_reset_check();

        send(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        send(64'h7,                   64'h5, 1'b1, 1'b1, 64'h2,                   1'b1, 1'b0);
        drain();

        for (int k = 0; k < 5; k++)
            chk($sformatf("cfg%0d drained", k), 64'(qsize[k]), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface and status flags. It is the successor to the datapath's single-cycle 64-bit combinational adder. It splits the carry chain into `STAGES` registered chunks so wide additions close timing, and it adds subtract mode, carry/overflow/zero flags and backpressure. It sits between the operand-select logic and the result writeback/compare path used by the sorting core.

## Interface
Parameters:
- `WIDTH`, default 64: operand and result width in bits. Must be a multiple of `STAGES`.
- `STAGES`, default 2: number of pipeline stages (1..8). Each stage adds a chunk of `CW = WIDTH/STAGES` bits.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: operands are presented.
- `in_ready`, out, 1: block accepts operands this cycle.
- `a`, in, `WIDTH`: operand A.
- `b`, in, `WIDTH`: operand B.
- `sub`, in, 1: 0 computes a+b; 1 computes a−b.
- `out_valid`, out, 1: result is valid.
- `out_ready`, in, 1: consumer accepts the result.
- `sum`, out, `WIDTH`: result modulo 2^WIDTH.
- `carry_out`, out, 1: carry out of bit `WIDTH`−1. In subtract mode this is 1 when there is no borrow (a ≥ b unsigned).
- `overflow`, out, 1: signed overflow.
- `zero`, out, 1: `sum` == 0.

## Operation
- Internal operand: b' = `sub` ? ~b : b. The carry-in to chunk 0 is `sub`.
- Stage k (0..`STAGES`−1):
  - Computes chunk k, bits [k·CW +: CW] = a_chunk + b'_chunk + carry_k.
  - Registers the chunk sum, carry_{k+1}, the lower result chunks already computed, and the still-unused upper a/b' chunks.
  - Carries a valid bit.
- The last stage register drives `sum`, `carry_out` (= carry_STAGES), `overflow` and `zero`.
- `overflow` = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]). It is computed in the final stage from the delayed operand MSBs.
- `zero` is computed combinationally from the final `sum` register. No extra latency.
- Pipeline advance: `adv` = !`out_valid` || `out_ready`.
  - `in_ready` = `adv`.
  - All stages shift together when `adv` = 1. When `adv` = 0 all stages hold.
  - Bubbles are carried as valid = 0.
- A transfer occurs on a rising edge where valid && ready. Inputs are ignored when `in_valid` = 0 or `in_ready` = 0.
- Outputs hold stable while `out_valid` = 1 && `out_ready` = 0.
- Arithmetic is unsigned modulo 2^WIDTH. Flags are the only width extension.

## Timing
- Reset (`reset` = 0 on a rising edge):
  - All stage valid bits clear; `out_valid` = 0.
  - `sum` = 0, `carry_out` = 0, `overflow` = 0, therefore `zero` = 1.
  - `in_ready` = 1 from the first cycle after reset.
  - Reset overrides any handshake in the same cycle.
  - Reset mid-operation discards all in-flight results; no partial result is ever presented.
- Latency: operands accepted on edge E0 are presented (`out_valid` = 1) in the cycle after edge E0+`STAGES`−1. With `STAGES` = 1 the result is visible in the cycle after acceptance.
- Throughput: one result per cycle while `out_ready` = 1.
- Backpressure: `in_ready` falls combinationally in the same cycle that `out_valid` = 1 && `out_ready` = 0.
  - When `out_ready` returns to 1, in that same edge the output is consumed, the pipeline shifts, and a new input may be accepted.
  - No result is lost or duplicated.
- Simultaneous output consume and input accept are legal and required at full rate.
- `sub` is sampled with its operands on acceptance. Mode may change on every transfer.

## Test plan
- Reset, `STAGES` = 2, `WIDTH` = 64: hold `reset` = 0 for 3 cycles → `out_valid` = 0, `sum` = 0, `zero` = 1, `in_ready` = 1.
- Carry across the chunk boundary: a = 0x0000_0000_FFFF_FFFF, b = 1, `sub` = 0 → two cycles later `sum` = 0x0000_0001_0000_0000, `carry_out` = 0, `overflow` = 0.
- Wrap and flags:
  - a = 0xFFFF_FFFF_FFFF_FFFF + b = 1 → `sum` = 0, `carry_out` = 1, `zero` = 1.
  - a = 0x7FFF_FFFF_FFFF_FFFF + 1 → `overflow` = 1.
- Subtract: a = 5, b = 7, `sub` = 1 → `sum` = 0xFFFF_FFFF_FFFF_FFFE, `carry_out` = 0.
  - a = 7, b = 5 → `sum` = 2, `carry_out` = 1.
- Backpressure: stream 10 back-to-back random transfers with `out_ready` toggling pseudo-randomly → results are in order, match the reference model bit-exactly, and none are lost or duplicated. Output holds stable during every stall.
- Sweep parameters `STAGES` ∈ {1, 4, 8} with `WIDTH` = 64, and `WIDTH` = 32 with `STAGES` = 4: assert reset mid-stream → in-flight results are dropped. Latency equals `STAGES` and is checked per configuration.
